// File: rtl/dmem_sync_if.sv
// -----------------------------------------------------------------------------
// dmem_sync_if
// Request/response bus between the execute stage and the synchronous data
// memory.
//
// Request channel (master -> slave unless noted):
//   req_valid    : request present
//   req_ready    : slave -> master, block can accept a request
//   req_we       : 0 = load, 1 = store
//   req_size     : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned : loads only, 1 = zero-extend, 0 = sign-extend
//   req_addr     : byte address
//   req_wdata    : right-aligned store data
// Response channel (slave -> master):
//   resp_valid   : one-cycle response pulse
//   resp_rdata   : extended load result, 0 for stores and errors
//   resp_err     : request was illegal and had no effect
// -----------------------------------------------------------------------------
interface dmem_sync_if #(
   parameter int ADDR_W = 32
);
   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [1:0]        req_size;
   logic              req_unsigned;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/dmem_sync.sv
// -----------------------------------------------------------------------------
// dmem_sync
// Synchronous data memory for the load/store path. Accepts one request at a
// time over a valid/ready handshake, performs RISC-V byte/half/word accesses
// with sign or zero extension on loads, and reports misaligned, illegal-size
// and out-of-range accesses as errors that leave the array untouched.
// Loads respond RD_LAT cycles after acceptance; stores and errors respond in
// the cycle after acceptance. There is no response backpressure.
//
// Parameters:
//   DEPTH  : number of 32-bit words (power of two, >= 8)
//   ADDR_W : byte-address width
//   RD_LAT : read latency in cycles, 1..4
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset (control and response registers
//            only; array contents survive reset)
//   bus    : dmem_sync_if slave modport (request and response channels)
// -----------------------------------------------------------------------------
module dmem_sync #(
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 32,
   parameter int RD_LAT = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   dmem_sync_if.slave  bus
);

   localparam int AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   typedef logic [31:0] mem_t [DEPTH];

   // Power-up image: word i holds its own byte address 4*i.
   function automatic mem_t mem_init();
      mem_t m;
      for (int i = 0; i < DEPTH; i++) begin
         m[i] = 32'(4 * i);
      end
      return m;
   endfunction

   // Shift the addressed bytes down to bit 0 and extend to 32 bits.
   function automatic logic [31:0] load_ext(
      input logic [31:0] word,
      input logic [1:0]  lane,
      input logic [1:0]  size,
      input logic        uns
   );
      logic [31:0] sh;
      sh = word >> {lane, 3'b000};
      case (size)
         2'b00:   return uns ? {24'd0, sh[7:0]}  : {{24{sh[7]}},  sh[7:0]};
         2'b01:   return uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   // Merge right-aligned store data into the addressed lanes of a word.
   function automatic logic [31:0] store_merge(
      input logic [31:0] old,
      input logic [31:0] wdata,
      input logic [1:0]  lane,
      input logic [1:0]  size
   );
      logic [31:0] r;
      r = old;
      case (size)
         2'b00:   r[{lane, 3'b000} +: 8]     = wdata[7:0];
         2'b01:   r[{lane[1], 4'b0000} +: 16] = wdata[15:0];
         2'b10:   r = wdata;
         default: r = old;
      endcase
      return r;
   endfunction

   mem_t mem = mem_init();

   state_t            state, state_n;
   logic [1:0]        cnt, cnt_n;
   logic [ADDR_W-3:0] widx;
   logic [1:0]        lane;
   logic [AW-1:0]     mi;
   logic              oor;
   logic              err_now;
   logic              accept;
   logic [31:0]       result_now;
   logic              load_resp;

   // Captured at the accept edge, presented when the response is loaded.
   logic [31:0]       rdata_p0;
   logic              err_p0;

   logic [31:0]       resp_rdata_q;
   logic              resp_err_q;

   // ---- decode / accept ----
   assign widx = bus.req_addr[ADDR_W-1:2];
   assign lane = bus.req_addr[1:0];
   assign mi   = widx[AW-1:0];

   // Any word-index bit at or above AW set means the index is >= DEPTH.
   assign oor = (widx >> AW) != '0;

   assign err_now = (bus.req_size == 2'b11)
                  | ((bus.req_size == 2'b01) & lane[0])
                  | ((bus.req_size == 2'b10) & (lane != 2'b00))
                  | oor;

   assign bus.req_ready = rst_n & (state == IDLE);
   assign accept        = bus.req_valid & bus.req_ready;

   always_comb begin
      result_now = 32'd0;
      if (!bus.req_we && !err_now) begin
         result_now = load_ext(mem[mi], lane, bus.req_size, bus.req_unsigned);
      end
   end

   // ---- array: stores commit at their accept edge ----
   always_ff @(posedge clk) begin
      if (accept && bus.req_we && !err_now) begin
         mem[mi] <= store_merge(mem[mi], bus.req_wdata, lane, bus.req_size);
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         rdata_p0 <= result_now;
         err_p0   <= err_now;
      end
   end

   // ---- control FSM ----
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (!bus.req_we && !err_now && (RD_LAT > 1)) begin
                  state_n = WAIT;
                  cnt_n   = 2'(RD_LAT - 1);
               end else begin
                  state_n = RESP;
               end
            end
         end
         WAIT: begin
            cnt_n = cnt - 2'd1;
            // Leave when the decremented count reaches zero so the
            // response lands exactly RD_LAT cycles after acceptance.
            if (cnt <= 2'd1) begin
               state_n = RESP;
            end
         end
         RESP: begin
            state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
         end
      endcase
   end

   // Response registers change only on entry to RESP, so they hold
   // their value between responses.
   assign load_resp = (state_n == RESP) && (state != RESP);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state        <= IDLE;
         cnt          <= 2'd0;
         resp_rdata_q <= 32'd0;
         resp_err_q   <= 1'b0;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         if (load_resp) begin
            resp_rdata_q <= (state == IDLE) ? result_now : rdata_p0;
            resp_err_q   <= (state == IDLE) ? err_now    : err_p0;
         end
      end
   end

   // ---- response ----
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_dmem_sync.sv
// -----------------------------------------------------------------------------
// tb_dmem_sync
// Two instances: u1 with RD_LAT = 1 and u3 with RD_LAT = 3, sharing clock,
// reset and request fields but with separate valids. Stimulus pushes the
// expected response (data, error flag, cycle due) into a per-instance queue;
// a negedge monitor pops and compares whenever resp_valid is seen.
// -----------------------------------------------------------------------------
module tb_dmem_sync;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_n = 1'b0;
   logic        val1 = 1'b0, val3 = 1'b0;
   logic        we = 1'b0, uns = 1'b0;
   logic [1:0]  size = 2'b10;
   logic [31:0] addr = 32'd0, wdata = 32'd0;

   dmem_sync_if #(.ADDR_W(32)) b1 ();
   dmem_sync_if #(.ADDR_W(32)) b3 ();

   assign b1.req_valid    = val1;
   assign b1.req_we       = we;
   assign b1.req_size     = size;
   assign b1.req_unsigned = uns;
   assign b1.req_addr     = addr;
   assign b1.req_wdata    = wdata;
   assign b3.req_valid    = val3;
   assign b3.req_we       = we;
   assign b3.req_size     = size;
   assign b3.req_unsigned = uns;
   assign b3.req_addr     = addr;
   assign b3.req_wdata    = wdata;

   dmem_sync #(.DEPTH(256), .ADDR_W(32), .RD_LAT(1)) u1 (
      .clk(clk), .rst_n(rst_n), .bus(b1));
   dmem_sync #(.DEPTH(256), .ADDR_W(32), .RD_LAT(3)) u3 (
      .clk(clk), .rst_n(rst_n), .bus(b3));

   typedef struct {
      logic [31:0] rd;
      logic        err;
      int          due;
      string       tag;
   } exp_t;

   exp_t q1[$];
   exp_t q3[$];
   exp_t e1, e3;
   int   tests = 0;
   int   fails = 0;
   int   cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, req);
      end
   endtask

   task automatic score(input string dut, input logic have, input exp_t e,
                        input logic [31:0] rd, input logic err);
      tests++;
      if (!have) begin
         fails++;
         $display("FAIL %s unexpected response at cycle %0d: rdata 0x%08h err %0b, expected none",
                  dut, cyc, rd, err);
      end else if (rd !== e.rd || err !== e.err || cyc != e.due) begin
         fails++;
         $display("FAIL %s %s: rdata 0x%08h err %0b cycle %0d, expected 0x%08h err %0b cycle %0d",
                  dut, e.tag, rd, err, cyc, e.rd, e.err, e.due);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (b1.resp_valid === 1'b1) begin
         logic h1;
         h1 = (q1.size() > 0);
         if (h1) e1 = q1.pop_front();
         score("u1", h1, e1, b1.resp_rdata, b1.resp_err);
      end
      if (b3.resp_valid === 1'b1) begin
         logic h3;
         h3 = (q3.size() > 0);
         if (h3) e3 = q3.pop_front();
         score("u3", h3, e3, b3.resp_rdata, b3.resp_err);
      end
   end

   // Issue one request to instance 1 or 3; returns #1 after the accept edge.
   task automatic op(input int which, input logic w, input logic [1:0] sz,
                     input logic u, input logic [31:0] a, input logic [31:0] wd,
                     input logic push, input logic [31:0] erd, input logic eerr,
                     input string tag);
      int   n;
      exp_t e;
      we = w; size = sz; uns = u; addr = a; wdata = wd;
      if (which == 1) val1 = 1'b1; else val3 = 1'b1;
      n = 0;
      while (((which == 1) ? b1.req_ready : b3.req_ready) !== 1'b1 && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 20) begin
         tests++;
         fails++;
         $display("FAIL %s: req_ready never high, expected within 20 cycles", tag);
         val1 = 1'b0; val3 = 1'b0;
         return;
      end
      @(posedge clk); #1;
      val1 = 1'b0; val3 = 1'b0;
      if (push) begin
         e.rd  = erd;
         e.err = eerr;
         e.tag = tag;
         e.due = cyc + ((w || eerr) ? 0 : which - 1);
         if (which == 1) q1.push_back(e); else q3.push_back(e);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation still running, expected $finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic exp_rdy [9];
      exp_rdy = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

      // Reset with a store presented throughout; it must be ignored.
      rst_n = 1'b0; val1 = 1'b1; val3 = 1'b1;
      we = 1'b1; size = 2'b10; addr = 32'h0C; wdata = 32'hDEADBEEF;
      repeat (3) @(posedge clk);
      #1;
      check("rst_ready_u1", {31'd0, b1.req_ready}, 32'd0);
      check("rst_ready_u3", {31'd0, b3.req_ready}, 32'd0);
      check("rst_valid_u1", {31'd0, b1.resp_valid}, 32'd0);
      check("rst_rdata_u1", b1.resp_rdata, 32'd0);
      check("rst_err_u1",   {31'd0, b1.resp_err}, 32'd0);
      val1 = 1'b0; val3 = 1'b0; we = 1'b0;
      rst_n = 1'b1;
      #1;
      check("rel_ready_u1", {31'd0, b1.req_ready}, 32'd1);

      // Basic read; also proves the store during reset had no effect.
      op(1, 0, 2'b10, 0, 32'h0C, 0, 1, 32'h0000000C, 0, "lw_0C");

      // Sub-word loads after a word store.
      op(1, 1, 2'b10, 0, 32'h10, 32'h80FF7F01, 1, 32'h0, 0, "sw_10");
      op(1, 0, 2'b00, 0, 32'h10, 0, 1, 32'h00000001, 0, "lb_10");
      op(1, 0, 2'b00, 0, 32'h12, 0, 1, 32'hFFFFFFFF, 0, "lb_12");
      op(1, 0, 2'b00, 1, 32'h12, 0, 1, 32'h000000FF, 0, "lbu_12");
      op(1, 0, 2'b01, 0, 32'h12, 0, 1, 32'hFFFF80FF, 0, "lh_12");
      op(1, 0, 2'b01, 1, 32'h12, 0, 1, 32'h000080FF, 0, "lhu_12");
      op(1, 0, 2'b00, 0, 32'h11, 0, 1, 32'h0000007F, 0, "lb_11");
      op(1, 0, 2'b00, 0, 32'h13, 0, 1, 32'hFFFFFF80, 0, "lb_13");
      op(1, 0, 2'b00, 1, 32'h13, 0, 1, 32'h00000080, 0, "lbu_13");
      op(1, 0, 2'b01, 0, 32'h10, 0, 1, 32'h00007F01, 0, "lh_10");
      op(1, 0, 2'b10, 0, 32'h10, 0, 1, 32'h80FF7F01, 0, "lw_10");

      // Partial stores leave the other lanes unchanged.
      op(1, 1, 2'b00, 0, 32'h15, 32'hFFFFFFAB, 1, 32'h0, 0, "sb_15");
      op(1, 1, 2'b01, 0, 32'h16, 32'hAAAA1234, 1, 32'h0, 0, "sh_16");
      op(1, 0, 2'b10, 0, 32'h14, 0, 1, 32'h1234AB14, 0, "lw_14");

      // Errors: rdata 0, err 1, array unchanged.
      op(1, 0, 2'b01, 0, 32'h01, 0, 1, 32'h0, 1, "err_lh_01");
      op(1, 1, 2'b10, 0, 32'h02, 32'hFFFFFFFF, 1, 32'h0, 1, "err_sw_02");
      op(1, 0, 2'b10, 0, 32'h00, 0, 1, 32'h00000000, 0, "lw_00_after_err");
      op(1, 0, 2'b11, 0, 32'h20, 0, 1, 32'h0, 1, "err_size11_rd");
      op(1, 1, 2'b11, 0, 32'h20, 32'hFFFFFFFF, 1, 32'h0, 1, "err_size11_wr");
      op(1, 0, 2'b10, 0, 32'h20, 0, 1, 32'h00000020, 0, "lw_20_after_err");
      op(1, 0, 2'b10, 0, 32'h400, 0, 1, 32'h0, 1, "err_lw_oor");
      op(1, 1, 2'b10, 0, 32'h400, 32'h55555555, 1, 32'h0, 1, "err_sw_oor");
      op(1, 0, 2'b10, 0, 32'h00, 0, 1, 32'h00000000, 0, "lw_00_after_oor");

      // RD_LAT = 3 back-to-back reads with req_valid held high. Fields are
      // changed to a store pattern during the wait cycles, which must be ignored.
      we = 1'b0; size = 2'b10; uns = 1'b0; addr = 32'h0C; val3 = 1'b1;
      for (int k = 0; k < 9; k++) begin
         if (k == 8) val3 = 1'b0;
         if (k == 1) begin
            exp_t e;
            e.rd = 32'h0000000C; e.err = 1'b0; e.due = cyc + 2; e.tag = "b2b_0";
            q3.push_back(e);
            addr = 32'h10; we = 1'b1; wdata = 32'hFFFFFFFF;
         end
         if (k == 4) we = 1'b0;
         if (k == 5) begin
            exp_t e;
            e.rd = 32'h00000010; e.err = 1'b0; e.due = cyc + 2; e.tag = "b2b_1";
            q3.push_back(e);
         end
         check($sformatf("b2b_ready_c%0d", k), {31'd0, b3.req_ready}, {31'd0, exp_rdy[k]});
         @(posedge clk); #1;
      end
      op(3, 0, 2'b10, 0, 32'h10, 0, 1, 32'h00000010, 0, "lw3_10_unchanged");

      // Reset in cycle 1 of a RD_LAT = 3 read: its response is dropped,
      // while the store accepted before it persists.
      op(3, 1, 2'b10, 0, 32'h30, 32'hCAFEF00D, 1, 32'h0, 0, "sw3_30");
      op(3, 0, 2'b10, 0, 32'h0C, 0, 1, 32'h0000000C, 0, "lw3_0C");
      op(3, 0, 2'b10, 0, 32'h34, 0, 0, 32'h0, 0, "lw3_34_dropped");
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("midrst_valid_u3", {31'd0, b3.resp_valid}, 32'd0);
      check("midrst_ready_u3", {31'd0, b3.req_ready}, 32'd0);
      check("midrst_rdata_u3", b3.resp_rdata, 32'd0);
      check("midrst_err_u3",   {31'd0, b3.resp_err}, 32'd0);
      rst_n = 1'b1;
      repeat (8) @(posedge clk);
      #1;
      op(3, 0, 2'b10, 0, 32'h30, 0, 1, 32'hCAFEF00D, 0, "lw3_30_after_rst");

      repeat (8) @(posedge clk);
      #1;
      check("q1_drained", q1.size(), 32'd0);
      check("q3_drained", q3.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
